// File: rtl/control_pkg.sv
// Shared types for the control sequencer: opcodes, ALU codes, FSM states
// and the registered control bundle.
package control_pkg;

   typedef enum logic [3:0] {
      OP_LI  = 4'b0000, OP_LD  = 4'b0001, OP_ST  = 4'b0010, OP_ADD = 4'b0011,
      OP_SUB = 4'b0100, OP_XOR = 4'b0101, OP_OR  = 4'b0110, OP_AND = 4'b0111,
      OP_JMP = 4'b1000, OP_BEQ = 4'b1001, OP_BLT = 4'b1010, OP_BGT = 4'b1011,
      OP_LSL = 4'b1100, OP_LSR = 4'b1101
   } opcode_e;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_XOR = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0010;
   localparam logic [3:0] ALU_LSL = 4'b0011;
   localparam logic [3:0] ALU_LSR = 4'b0100;
   localparam logic [3:0] ALU_ADD = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_BLT = 4'b0111;
   localparam logic [3:0] ALU_BGT = 4'b1000;
   localparam logic [3:0] ALU_BEQ = 4'b1001;
   localparam logic [3:0] ALU_NOP = 4'b1111;

   typedef enum logic {IDLE = 1'b0, MEM = 1'b1} state_e;

   typedef struct packed {
      logic       branch;
      logic       mem_to_reg;
      logic       mem_write;
      logic       reg_write;
      logic       imm_to_reg;
      logic [3:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{branch: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0,
                                   reg_write: 1'b0, imm_to_reg: 1'b0, alu_op: ALU_NOP};

endpackage

// File: rtl/control_seq_if.sv
// Fetch-to-control handshake and registered control bundle.
interface control_seq_if #(
   parameter int IW        = 9,
   parameter int PUT_DEPTH = 2
);
   localparam int VW = IW - 1;
   localparam int CW = $clog2(PUT_DEPTH) + 1;

   logic          instr_valid;
   logic [IW-1:0] instruction;
   logic          stall;
   logic          ctrl_valid;
   logic          branchFlag;
   logic          memToRegFlag;
   logic          memWriteFlag;
   logic          regWriteFlag;
   logic          immtoRegFlag;
   logic [3:0]    ALUOp;
   logic [VW-1:0] operand;
   logic          operand_valid;
   logic [CW-1:0] put_count;
   logic          put_overflow;
   logic          illegal;

   modport master (
      output instr_valid, instruction,
      input  stall, ctrl_valid, branchFlag, memToRegFlag, memWriteFlag, regWriteFlag,
             immtoRegFlag, ALUOp, operand, operand_valid, put_count, put_overflow, illegal
   );

   modport slave (
      input  instr_valid, instruction,
      output stall, ctrl_valid, branchFlag, memToRegFlag, memWriteFlag, regWriteFlag,
             immtoRegFlag, ALUOp, operand, operand_valid, put_count, put_overflow, illegal
   );
endinterface

// File: rtl/control_seq_put_fifo.sv
// Circular operand buffer; a push into a full buffer drops the oldest entry.
module put_fifo #(
   parameter int PUT_DEPTH = 2,
   parameter int VW        = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [VW-1:0]                din,
   output logic [VW-1:0]                head,
   output logic [$clog2(PUT_DEPTH):0]   count,
   output logic                         full,
   output logic                         empty
);
   localparam int AW = $clog2(PUT_DEPTH);

   logic [VW-1:0] mem_r [PUT_DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;

   assign full  = (count_r == (AW+1)'(PUT_DEPTH));
   assign empty = (count_r == {(AW+1){1'b0}});
   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;

   // Storage, pointers and occupancy; push and pop never coincide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PUT_DEPTH; i++) mem_r[i] <= {VW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else if (push) begin
         mem_r[wr_ptr_r] <= din;
         wr_ptr_r        <= wr_ptr_r + AW'(1);
         if (full) rd_ptr_r <= rd_ptr_r + AW'(1);
         else      count_r  <= count_r + (AW+1)'(1);
      end else if (pop && !empty) begin
         rd_ptr_r <= rd_ptr_r + AW'(1);
         count_r  <= count_r - (AW+1)'(1);
      end else begin
         count_r <= count_r;
      end
   end
endmodule

// File: rtl/control_seq.sv
// Registered instruction-control sequencer: decodes put/run instructions,
// stages put immediates and stretches load/store over MEM_LAT cycles.
module control_seq import control_pkg::*; #(
   parameter int IW        = 9,
   parameter int VW        = IW - 1,
   parameter int PUT_DEPTH = 2,
   parameter int MEM_LAT   = 2
) (
   input  logic         clk,
   input  logic         reset,
   control_seq_if.slave bus
);
   localparam int CW = $clog2(PUT_DEPTH) + 1;
   localparam int LW = $clog2(MEM_LAT) + 1;

   state_e        state_r;
   logic [LW-1:0] cnt_r;
   ctrl_t         ctrl_r;
   logic          ctrl_valid_r;
   logic [VW-1:0] operand_r;
   logic          operand_valid_r;
   logic          put_overflow_r;
   logic          illegal_r;

   logic          stall_s, accept_s, is_put_s, is_mem_s, push_s, pop_s;
   logic [3:0]    opcode_s;
   logic [VW-1:0] head_s;
   logic [CW-1:0] count_s;
   logic          full_s, empty_s;

   // Load regWrite is only raised on the last memory cycle, hence last_mem.
   function automatic ctrl_t decode(input logic [3:0] op, input logic last_mem);
      ctrl_t c;
      c = CTRL_IDLE;
      case (op)
         OP_LI:   begin c.imm_to_reg = 1'b1; c.reg_write = 1'b1; end
         OP_LD:   begin c.mem_to_reg = 1'b1; c.reg_write = last_mem; end
         OP_ST:   c.mem_write = 1'b1;
         OP_ADD:  begin c.alu_op = ALU_ADD; c.reg_write = 1'b1; end
         OP_SUB:  begin c.alu_op = ALU_SUB; c.reg_write = 1'b1; end
         OP_XOR:  begin c.alu_op = ALU_XOR; c.reg_write = 1'b1; end
         OP_OR:   begin c.alu_op = ALU_OR;  c.reg_write = 1'b1; end
         OP_AND:  begin c.alu_op = ALU_AND; c.reg_write = 1'b1; end
         OP_JMP:  c.branch = 1'b1;
         OP_BEQ:  c.alu_op = ALU_BEQ;
         OP_BLT:  c.alu_op = ALU_BLT;
         OP_BGT:  c.alu_op = ALU_BGT;
         OP_LSL:  begin c.alu_op = ALU_LSL; c.reg_write = 1'b1; end
         OP_LSR:  begin c.alu_op = ALU_LSR; c.reg_write = 1'b1; end
         default: c = CTRL_IDLE;
      endcase
      return c;
   endfunction

   assign stall_s  = (state_r == MEM);
   assign accept_s = bus.instr_valid && !stall_s;
   assign is_put_s = bus.instruction[0];
   assign opcode_s = bus.instruction[4:1];
   assign is_mem_s = !is_put_s && ((opcode_s == OP_LD) || (opcode_s == OP_ST));
   assign push_s   = accept_s && is_put_s;
   assign pop_s    = accept_s && !is_put_s;

   put_fifo #(.PUT_DEPTH(PUT_DEPTH), .VW(VW)) u_put_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .pop   (pop_s),
      .din   (bus.instruction[IW-1:1]),
      .head  (head_s),
      .count (count_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Sequencer FSM, latency counter and registered control bundle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r         <= IDLE;
         cnt_r           <= {LW{1'b0}};
         ctrl_r          <= CTRL_IDLE;
         ctrl_valid_r    <= 1'b0;
         operand_r       <= {VW{1'b0}};
         operand_valid_r <= 1'b0;
         put_overflow_r  <= 1'b0;
         illegal_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (push_s) begin
                  ctrl_r          <= CTRL_IDLE;
                  ctrl_valid_r    <= 1'b1;
                  operand_r       <= {VW{1'b0}};
                  operand_valid_r <= 1'b0;
                  if (full_s) put_overflow_r <= 1'b1;
               end else if (pop_s) begin
                  ctrl_r          <= decode(opcode_s, !(is_mem_s && (MEM_LAT > 1)));
                  ctrl_valid_r    <= 1'b1;
                  operand_r       <= empty_s ? {VW{1'b0}} : head_s;
                  operand_valid_r <= !empty_s;
                  if (opcode_s[3:1] == 3'b111) illegal_r <= 1'b1;
                  if (is_mem_s && (MEM_LAT > 1)) begin
                     state_r <= MEM;
                     cnt_r   <= LW'(MEM_LAT - 1);
                  end
               end else begin
                  ctrl_r          <= CTRL_IDLE;
                  ctrl_valid_r    <= 1'b0;
                  operand_r       <= {VW{1'b0}};
                  operand_valid_r <= 1'b0;
               end
            end
            MEM: begin
               // Bundle stays put; the last cycle drops stall and lets a load write back.
               if (cnt_r == LW'(1)) begin
                  state_r          <= IDLE;
                  ctrl_r.reg_write <= ctrl_r.mem_to_reg;
               end
               cnt_r <= cnt_r - LW'(1);
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign bus.stall         = stall_s;
   assign bus.ctrl_valid    = ctrl_valid_r;
   assign bus.branchFlag    = ctrl_r.branch;
   assign bus.memToRegFlag  = ctrl_r.mem_to_reg;
   assign bus.memWriteFlag  = ctrl_r.mem_write;
   assign bus.regWriteFlag  = ctrl_r.reg_write;
   assign bus.immtoRegFlag  = ctrl_r.imm_to_reg;
   assign bus.ALUOp         = ctrl_r.alu_op;
   assign bus.operand       = operand_r;
   assign bus.operand_valid = operand_valid_r;
   assign bus.put_count     = count_s;
   assign bus.put_overflow  = put_overflow_r;
   assign bus.illegal       = illegal_r;
endmodule
